// File: rtl/sparse_sampler_pkg.sv
// Shared constants and FSM encoding for the sparse index sampler and its companion blocks.
// The geometry here sets the default sizes used by the sampler.
package sparse_sampler_pkg;

  localparam int r        = 10163;
  localparam int H_WT     = 71;
  localparam int H_ADDR_W = 7;
  localparam int H_DAT_W  = 14;
  localparam int RND_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CHECK,
    SCAN,
    WRITE,
    FIN
  } state_t;

endpackage

// File: rtl/sparse_sampler.sv
// Draws H_WT distinct indices in 0..r-1 from a random word stream and writes them to h memory,
// rejecting out-of-range words and duplicates found by scanning the entries already written.
module sparse_sampler #(
  parameter int r        = sparse_sampler_pkg::r,
  parameter int H_WT     = sparse_sampler_pkg::H_WT,
  parameter int H_ADDR_W = sparse_sampler_pkg::H_ADDR_W,
  parameter int H_DAT_W  = sparse_sampler_pkg::H_DAT_W,
  parameter int RND_W    = sparse_sampler_pkg::RND_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                done,
  input  logic                rnd_valid,
  input  logic [RND_W-1:0]    rnd_data,
  output logic                rnd_ready,
  output logic [H_ADDR_W-1:0] h_addra,
  output logic                h_wea,
  output logic [H_DAT_W-1:0]  h_douta,
  output logic [H_ADDR_W-1:0] h_addrb,
  input  logic [H_DAT_W-1:0]  h_dinb
);

  import sparse_sampler_pkg::*;

  localparam logic [H_ADDR_W-1:0] WT_CNT = H_ADDR_W'(H_WT);
  localparam logic [H_DAT_W-1:0]  R_LIM  = H_DAT_W'(r);

  state_t              state, state_nxt;
  logic [H_ADDR_W-1:0] wcnt;
  logic [H_DAT_W-1:0]  cand;
  logic                pend;   // h_dinb carries data for the address issued last cycle
  logic                last;   // that address was the final one of the scan
  logic                hit;
  logic                final_addr;
  logic                unused_rnd_hi;

  assign unused_rnd_hi = ^rnd_data[RND_W-1:H_DAT_W];
  assign hit           = pend && (h_dinb == cand);
  assign final_addr    = (h_addrb + 1'b1) == wcnt;

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: if (rnd_valid) state_nxt = CHECK;
      CHECK: begin
        if (cand >= R_LIM)     state_nxt = FETCH;
        else if (wcnt == '0)   state_nxt = WRITE;
        else                   state_nxt = SCAN;
      end
      SCAN: begin
        if (hit)       state_nxt = FETCH;
        else if (last) state_nxt = WRITE;
      end
      WRITE: state_nxt = ((wcnt + 1'b1) == WT_CNT) ? FIN : FETCH;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rnd_ready = (state == FETCH);
  assign h_wea     = (state == WRITE);
  assign h_addra   = h_wea ? wcnt : '0;
  assign h_douta   = cand;
  assign done      = (state == FIN);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      cand    <= '0;
      h_addrb <= '0;
      pend    <= 1'b0;
      last    <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE:  if (start) wcnt <= '0;
        FETCH: if (rnd_valid) cand <= rnd_data[H_DAT_W-1:0];
        CHECK: begin
          h_addrb <= '0;
          pend    <= 1'b0;
          last    <= 1'b0;
        end
        SCAN: begin
          pend <= 1'b1;
          last <= final_addr;
          if (!final_addr) h_addrb <= h_addrb + 1'b1;
        end
        WRITE: wcnt <= wcnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_sampler.sv
// Scoreboard bench for sparse_sampler: stimulus pushes expected h writes, a monitor pops them
// as the DUT writes; a behavioural h memory with one-cycle read latency closes the scan loop.
module tb_sparse_sampler;

  import sparse_sampler_pkg::*;

  localparam int AW = H_ADDR_W;
  localparam int DW = H_DAT_W;

  logic            clk = 1'b0;
  logic            rst, start, done, rnd_valid, rnd_ready, h_wea;
  logic [RND_W-1:0] rnd_data;
  logic [AW-1:0]   h_addra, h_addrb;
  logic [DW-1:0]   h_douta, h_dinb;
  logic [DW-1:0]   mem [0:(1<<AW)-1];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass = 0;
  int  n_total = 0;
  int  done_seen = 0;
  int  run_writes = 0;

  always #5 clk = ~clk;

  sparse_sampler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .done      (done),
    .rnd_valid (rnd_valid),
    .rnd_data  (rnd_data),
    .rnd_ready (rnd_ready),
    .h_addra   (h_addra),
    .h_wea     (h_wea),
    .h_douta   (h_douta),
    .h_addrb   (h_addrb),
    .h_dinb    (h_dinb)
  );

  always @(posedge clk) begin
    h_dinb <= mem[h_addrb];
    if (h_wea) mem[h_addra] <= h_douta;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Monitor: every write the DUT issues must match the head of the expectation queue.
  always @(negedge clk) begin
    wr_t e;
    if (h_wea) begin
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr", 32'(h_addra), 32'(e.addr));
        check("write_data", 32'(h_douta), 32'(e.data));
      end
      run_writes++;
    end
    if (done) begin
      done_seen++;
      check("done_after_all_writes", 32'(run_writes), 32'(H_WT));
    end
  end

  function automatic logic [RND_W-1:0] val(input int i);
    return RND_W'(i * 137 + 3);
  endfunction

  task automatic push(input int addr, input int data);
    wr_t e;
    e.addr = AW'(addr);
    e.data = DW'(data);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    rnd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_writes = 0;
  endtask

  // Presents one word and returns on the negedge after it has been consumed.
  task automatic send(input logic [RND_W-1:0] w, input bit keep_valid);
    int n = 0;
    rnd_data  = w;
    rnd_valid = 1'b1;
    while (!rnd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!rnd_ready) begin
      check("rnd_ready_within_budget", 32'(rnd_ready), 32'd1);
      return;
    end
    @(negedge clk);
    if (!keep_valid) rnd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_rnd_ready"}, 32'(rnd_ready), 32'd0);
    check({tag, "_h_wea"},     32'(h_wea),     32'd0);
    check({tag, "_h_addra"},   32'(h_addra),   32'd0);
    check({tag, "_h_douta"},   32'(h_douta),   32'd0);
    check({tag, "_h_addrb"},   32'(h_addrb),   32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rnd_valid = 1'b0;
    rnd_data = '0;
    @(negedge clk);
    do_reset();
    check_reset_outputs("por");

    // Duplicate 5 is rejected after a scan.
    do_start();
    check("fetch_ready", 32'(rnd_ready), 32'd1);
    push(0, 5); push(1, 9); push(2, 12);
    send(16'd5, 1'b0); send(16'd9, 1'b0); send(16'd5, 1'b0); send(16'd12, 1'b0);
    drain();

    // Range boundary, index 0, duplicates at both scan positions.
    do_reset();
    do_start();
    push(0, 10162); push(1, 0); push(2, 300);
    send(16'h3FFF, 1'b0); send(16'd10163, 1'b0); send(16'h27B2, 1'b0);
    send(16'd0, 1'b0); send(16'd10162, 1'b0); send(16'd0, 1'b0); send(16'd300, 1'b0);
    drain();
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      check("hold_in_fetch", 32'({rnd_ready, h_wea, done, h_douta, h_addrb}),
            32'({1'b1, 1'b0, 1'b0, 14'd300, 7'd1}));
      @(negedge clk);
    end
    push(3, 77);
    send(16'd77, 1'b0);
    drain();

    // Reset mid-run after 30 writes.
    do_reset();
    do_start();
    for (int i = 0; i < 30; i++) begin
      push(i, int'(val(i)));
      send(val(i), 1'b1);
    end
    drain();
    rnd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_run_rst");
    rst = 1'b0;
    @(negedge clk);

    // Full run restarting at address 0, with duplicates and an ignored start.
    do_start();
    for (int i = 0; i < H_WT; i++) begin
      if (i == 35) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      push(i, int'(val(i)));
      send(val(i), 1'b1);
      if (i % 10 == 9) send(val(i - 5), 1'b1);
    end
    drain();
    begin
      int n = 0;
      while (!done && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("idle_after_fin", 32'({rnd_ready, h_wea, h_addra}), 32'd0);
      @(negedge clk);
    end
    rnd_valid = 1'b0;
    check("done_count", 32'(done_seen), 32'd1);
    check("run_write_count", 32'(run_writes), 32'(H_WT));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
